// File: rtl/controlador_dispensador.sv
// Cash-dispenser sequencer: splits an amount into bills (largest first) and strobes one bill at a time.
// Optional feature REINTENTO_ATASCO_EN: re-strobe a bill once after its first timeout before declaring a jam.
module controlador_dispensador #(
  parameter logic [31:0] D0        = 32'd1000,
  parameter logic [31:0] D1        = 32'd5000,
  parameter logic [31:0] D2        = 32'd10000,
  parameter logic [31:0] D3        = 32'd20000,
  parameter logic [31:0] MAX_MONTO = 32'd200000,
  parameter int          TIMEOUT   = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENTREGAR_DINERO,
  input  logic [31:0] MONTO,
  input  logic        BILLETE_LISTO,
  output logic        DISPENSAR_STB,
  output logic [1:0]  DENOMINACION,
  output logic        OCUPADO,
  output logic        ENTREGA_COMPLETA,
  output logic        ERROR_MONTO,
  output logic        ERROR_ATASCO,
  output logic [7:0]  BILLETES_ENTREGADOS
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    REPOSO, VALIDAR, SELECCIONAR, PEDIR, ESPERAR, FIN, BLOQUEADO
  } estado_t;

  estado_t           estado, estado_sig;
  logic [31:0]       restante;
  logic [CNT_W-1:0]  contador;
  logic [1:0]        denom_q;
  logic [1:0]        denom_sel;
  logic [7:0]        billetes_q;
  logic              err_monto_q;
  logic              err_atasco_q;
  logic [31:0]       valor_actual;
  logic              monto_invalido;
  logic              tiempo_agotado;
`ifdef REINTENTO_ATASCO_EN
  logic              reintento_q;
`endif

  assign monto_invalido = (restante == 32'd0) || (restante > MAX_MONTO) || ((restante % D0) != 32'd0);
  assign tiempo_agotado = (contador == CNT_W'(TIMEOUT - 1));

  always_comb begin
    valor_actual = D0;
    case (denom_q)
      2'd0: valor_actual = D0;
      2'd1: valor_actual = D1;
      2'd2: valor_actual = D2;
      2'd3: valor_actual = D3;
      default: valor_actual = D0;
    endcase
  end

  // Greedy pick; validation already guarantees restante >= D0 here.
  always_comb begin
    denom_sel = 2'd0;
    if (restante >= D3)      denom_sel = 2'd3;
    else if (restante >= D2) denom_sel = 2'd2;
    else if (restante >= D1) denom_sel = 2'd1;
    else                     denom_sel = 2'd0;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) estado <= REPOSO;
    else        estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO:      if (ENTREGAR_DINERO) estado_sig = VALIDAR;
      VALIDAR:     estado_sig = monto_invalido ? REPOSO : SELECCIONAR;
      SELECCIONAR: estado_sig = PEDIR;
      PEDIR:       estado_sig = ESPERAR;
      ESPERAR: begin
        if (BILLETE_LISTO) begin
          estado_sig = (restante == valor_actual) ? FIN : SELECCIONAR;
        end else if (tiempo_agotado) begin
`ifdef REINTENTO_ATASCO_EN
          estado_sig = reintento_q ? BLOQUEADO : PEDIR;
`else
          estado_sig = BLOQUEADO;
`endif
        end
      end
      FIN:         estado_sig = REPOSO;
      BLOQUEADO:   estado_sig = BLOQUEADO;
      default:     estado_sig = REPOSO;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      restante     <= 32'd0;
      contador     <= '0;
      denom_q      <= 2'd0;
      billetes_q   <= 8'd0;
      err_monto_q  <= 1'b0;
      err_atasco_q <= 1'b0;
`ifdef REINTENTO_ATASCO_EN
      reintento_q  <= 1'b0;
`endif
    end else begin
      err_monto_q <= (estado == VALIDAR) && monto_invalido;
      if ((estado == ESPERAR) && (estado_sig == BLOQUEADO)) err_atasco_q <= 1'b1;
      case (estado)
        REPOSO: begin
          if (ENTREGAR_DINERO) begin
            restante   <= MONTO;
            billetes_q <= 8'd0;
          end
        end
        SELECCIONAR: denom_q  <= denom_sel;
        PEDIR:       contador <= '0;
        ESPERAR: begin
          if (BILLETE_LISTO) begin
            restante <= restante - valor_actual;
            if (billetes_q != 8'hFF) billetes_q <= billetes_q + 8'd1;
`ifdef REINTENTO_ATASCO_EN
            reintento_q <= 1'b0;
`endif
          end else if (!tiempo_agotado) begin
            contador <= contador + CNT_W'(1);
          end else begin
`ifdef REINTENTO_ATASCO_EN
            reintento_q <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign DISPENSAR_STB       = (estado == PEDIR);
  assign ENTREGA_COMPLETA    = (estado == FIN);
  assign OCUPADO             = (estado != REPOSO);
  assign DENOMINACION        = denom_q;
  assign ERROR_MONTO         = err_monto_q;
  assign ERROR_ATASCO        = err_atasco_q;
  assign BILLETES_ENTREGADOS = billetes_q;

endmodule

// File: tb/tb_controlador_dispensador.sv
// Directed self-checking bench for controlador_dispensador; an automatic responder acks bills 2 cycles after each strobe.
module tb_controlador_dispensador;

  logic        CLK;
  logic        RESET;
  logic        ENTREGAR_DINERO;
  logic [31:0] MONTO;
  logic        BILLETE_LISTO = 1'b0;
  logic        DISPENSAR_STB;
  logic [1:0]  DENOMINACION;
  logic        OCUPADO;
  logic        ENTREGA_COMPLETA;
  logic        ERROR_MONTO;
  logic        ERROR_ATASCO;
  logic [7:0]  BILLETES_ENTREGADOS;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int stb_total = 0;
  int completa_total = 0;
  int err_monto_total = 0;
  int ack_cd = 0;
  logic ack_en = 1'b0;
  int codes [0:255];
  int stb_cyc [0:255];
  int start_cyc;

  controlador_dispensador dut (
    .CLK(CLK), .RESET(RESET), .ENTREGAR_DINERO(ENTREGAR_DINERO), .MONTO(MONTO),
    .BILLETE_LISTO(BILLETE_LISTO), .DISPENSAR_STB(DISPENSAR_STB), .DENOMINACION(DENOMINACION),
    .OCUPADO(OCUPADO), .ENTREGA_COMPLETA(ENTREGA_COMPLETA), .ERROR_MONTO(ERROR_MONTO),
    .ERROR_ATASCO(ERROR_ATASCO), .BILLETES_ENTREGADOS(BILLETES_ENTREGADOS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Mechanism model: logs every strobe and acks it during the second cycle after it.
  always @(negedge CLK) begin
    BILLETE_LISTO = 1'b0;
    if (!RESET) begin
      ack_cd = 0;
    end else begin
      if (ack_cd > 0) begin
        ack_cd--;
        if (ack_cd == 0) BILLETE_LISTO = 1'b1;
      end
      if (DISPENSAR_STB) begin
        if (stb_total < 256) begin
          codes[stb_total]   = int'(DENOMINACION);
          stb_cyc[stb_total] = cyc;
        end
        stb_total++;
        if (ack_en) ack_cd = 2;
      end
      if (ENTREGA_COMPLETA) completa_total++;
      if (ERROR_MONTO)      err_monto_total++;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] monto);
    ENTREGAR_DINERO = 1'b1;
    MONTO = monto;
    start_cyc = cyc;
    tick();
    ENTREGAR_DINERO = 1'b0;
  endtask

  task automatic waitCompleta(input int base);
    for (int i = 0; i < 200 && completa_total == base; i++) tick();
  endtask

  int base_stb, base_cmp, base_err, exp_jam_cyc, exp_jam_stb;
  int exp38 [6] = '{3, 2, 1, 0, 0, 0};

  initial begin
    RESET = 1'b0;
    ENTREGAR_DINERO = 1'b0;
    MONTO = 32'd0;
    tick();
    tick();
    checkOutput("rst_ocupado", OCUPADO, 1'b0);
    checkOutput("rst_stb", DISPENSAR_STB, 1'b0);
    checkOutput("rst_denom", DENOMINACION, 2'd0);
    checkOutput("rst_completa", ENTREGA_COMPLETA, 1'b0);
    checkOutput("rst_err_monto", ERROR_MONTO, 1'b0);
    checkOutput("rst_err_atasco", ERROR_ATASCO, 1'b0);
    checkOutput("rst_billetes", BILLETES_ENTREGADOS, 8'd0);
    RESET = 1'b1;
    tick();

    // 38000 -> 20000 + 10000 + 5000 + 3 x 1000
    ack_en = 1'b1;
    base_stb = stb_total;
    base_cmp = completa_total;
    applyStimulus(32'd38000);
    checkOutput("m38_ocupado", OCUPADO, 1'b1);
    waitCompleta(base_cmp);
    checkOutput("m38_completa", completa_total - base_cmp, 1);
    checkOutput("m38_strobes", stb_total - base_stb, 6);
    for (int i = 0; i < 6; i++) checkOutput($sformatf("m38_code%0d", i), codes[base_stb + i], exp38[i]);
    checkOutput("m38_latency", stb_cyc[base_stb] - start_cyc, 3);
    checkOutput("m38_billetes", BILLETES_ENTREGADOS, 8'd6);
    checkOutput("m38_idle", OCUPADO, 1'b0);

    // 1500 is not a multiple of the smallest bill
    base_stb = stb_total;
    applyStimulus(32'd1500);
    checkOutput("m1500_err_early", ERROR_MONTO, 1'b0);
    tick();
    checkOutput("m1500_err_pulse", ERROR_MONTO, 1'b1);
    checkOutput("m1500_ocupado", OCUPADO, 1'b0);
    tick();
    checkOutput("m1500_err_end", ERROR_MONTO, 1'b0);
    checkOutput("m1500_strobes", stb_total - base_stb, 0);

    base_err = err_monto_total;
    applyStimulus(32'd250000);
    repeat (3) tick();
    checkOutput("m250k_err", err_monto_total - base_err, 1);
    applyStimulus(32'd0);
    repeat (3) tick();
    checkOutput("m0_err", err_monto_total - base_err, 2);
    checkOutput("m_bad_strobes", stb_total - base_stb, 0);

    // A second request while busy must be dropped
    base_stb = stb_total;
    base_cmp = completa_total;
    applyStimulus(32'd30000);
    repeat (3) tick();
    ENTREGAR_DINERO = 1'b1;
    MONTO = 32'd5000;
    repeat (4) tick();
    ENTREGAR_DINERO = 1'b0;
    waitCompleta(base_cmp);
    checkOutput("m30k_completa", completa_total - base_cmp, 1);
    checkOutput("m30k_strobes", stb_total - base_stb, 2);
    checkOutput("m30k_code0", codes[base_stb], 3);
    checkOutput("m30k_code1", codes[base_stb + 1], 2);
    checkOutput("m30k_billetes", BILLETES_ENTREGADOS, 8'd2);
    repeat (5) tick();
    checkOutput("m30k_no_queue", stb_total - base_stb, 2);
    checkOutput("m30k_idle", OCUPADO, 1'b0);

    // Reset while waiting for the ack of a 10000 bill
    ack_en = 1'b0;
    base_stb = stb_total;
    applyStimulus(32'd10000);
    repeat (3) tick();
    RESET = 1'b0;
    #1;
    checkOutput("rmid_ocupado", OCUPADO, 1'b0);
    checkOutput("rmid_stb", DISPENSAR_STB, 1'b0);
    checkOutput("rmid_denom", DENOMINACION, 2'd0);
    checkOutput("rmid_billetes", BILLETES_ENTREGADOS, 8'd0);
    repeat (2) tick();
    RESET = 1'b1;
    repeat (2) tick();
    checkOutput("rmid_strobes", stb_total - base_stb, 1);
    ack_en = 1'b1;
    base_stb = stb_total;
    base_cmp = completa_total;
    applyStimulus(32'd1000);
    waitCompleta(base_cmp);
    checkOutput("m1000_completa", completa_total - base_cmp, 1);
    checkOutput("m1000_strobes", stb_total - base_stb, 1);
    checkOutput("m1000_code", codes[base_stb], 0);
    checkOutput("m1000_billetes", BILLETES_ENTREGADOS, 8'd1);

    // Jam: no ack ever arrives
`ifdef REINTENTO_ATASCO_EN
    exp_jam_cyc = 37;
    exp_jam_stb = 2;
`else
    exp_jam_cyc = 20;
    exp_jam_stb = 1;
`endif
    tick();
    ack_en = 1'b0;
    base_stb = stb_total;
    applyStimulus(32'd20000);
    repeat (exp_jam_cyc - 2) tick();
    checkOutput("jam_not_yet", ERROR_ATASCO, 1'b0);
    tick();
    checkOutput("jam_set", ERROR_ATASCO, 1'b1);
    checkOutput("jam_strobes", stb_total - base_stb, exp_jam_stb);
    checkOutput("jam_ocupado", OCUPADO, 1'b1);
    ack_en = 1'b1;
    applyStimulus(32'd1000);
    repeat (10) tick();
    checkOutput("jam_ignored", stb_total - base_stb, exp_jam_stb);
    checkOutput("jam_sticky", ERROR_ATASCO, 1'b1);
    checkOutput("jam_still_busy", OCUPADO, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
